// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern and length, optional
// overlapping matches, and a saturating match counter.
module seq_detector_param #(
    parameter int              PAT_W   = 8,
    parameter int              CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0010_1001),
    parameter int              DEF_LEN = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stream_valid,
    input  logic                     stream_bit,
    input  logic                     pat_load,
    input  logic [PAT_W-1:0]         pat_value,
    input  logic [$clog2(PAT_W):0]   pat_len,
    input  logic                     overlap_en,
    input  logic                     cnt_clr,
    output logic                     tone,
    output logic [CNT_W-1:0]         count,
    output logic                     cnt_sat,
    output logic                     cfg_err
);

    localparam int               LEN_W   = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_sync;
    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fill;
    logic             r_tone;
    logic             r_cfgErr;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_run;
    logic             w_accept;
    logic             w_lenOk;
    logic             w_match;
    logic [PAT_W-1:0] w_histNext;
    logic [LEN_W-1:0] w_fillNext;
    logic [PAT_W-1:0] w_mask;

    // Reset release is synchronised; no bit or load is taken until it is through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run      = r_sync[1];
    assign w_accept   = w_run && stream_valid && !pat_load;
    assign w_lenOk    = (pat_len >= LEN_W'(2)) && (pat_len <= MAX_LEN);
    assign w_histNext = {r_hist[PAT_W-2:0], stream_bit};
    assign w_fillNext = (r_fill == MAX_LEN) ? r_fill : r_fill + 1'b1;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_accept && ((w_histNext & w_mask) == (r_pat & w_mask))
                     && (w_fillNext >= r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_pat    <= DEF_PAT;
            r_len    <= LEN_W'(DEF_LEN);
            r_tone   <= 1'b0;
            r_cfgErr <= 1'b0;
        end else begin
            r_tone   <= w_match;
            r_cfgErr <= w_run && pat_load && !w_lenOk;
            if (w_run && pat_load && w_lenOk) begin
                r_pat  <= pat_value;
                r_len  <= pat_len;
                r_hist <= '0;
                r_fill <= '0;
            end else if (w_accept) begin
                r_hist <= w_histNext;
                r_fill <= (w_match && !overlap_en) ? '0 : w_fillNext;
            end
        end
    end

    // A clear coinciding with a match leaves that match counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (cnt_clr) begin
            r_count <= w_match ? CNT_W'(1) : '0;
            r_sat   <= 1'b0;
        end else if (w_match) begin
            if (r_count == CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                if (r_count == CNT_MAX - 1'b1) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign tone    = r_tone;
    assign count   = r_count;
    assign cnt_sat = r_sat;
    assign cfg_err = r_cfgErr;

endmodule
